// File: rtl/divisor_rest_pkg.sv
// rtl/divisor_rest_pkg.sv - shared state encodings and default width for the restoring divider
package divisor_rest_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    CARGA    = 3'b001,
    DESPLAZA = 3'b010,
    RESTA    = 3'b011,
    FIN      = 3'b100
  } state_t;

endpackage

// File: rtl/divisor_rest_cd_divisor.sv
// rtl/divisor_rest_cd_divisor.sv - datapath: A/Q/M registers, trial subtractor, iteration counter
module cd_divisor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         carga,
  input  logic         desplaza,
  input  logic         resta_ok,
  input  logic         decrementa,
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  output logic         cero,
  output logic         menor,
  output logic         div0,
  output logic [N:0]   a,
  output logic [N-1:0] q,
  output logic         dz
);

  localparam int CNT_W = $clog2(N + 1);

  logic [N:0]       a_q, a_d;
  logic [N-1:0]     q_q, q_d;
  logic [N-1:0]     m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic [N:0]       diff;

  // Sign bit of the N+1-bit trial difference says A < M, i.e. restore.
  assign diff  = a_q - {1'b0, m_q};
  assign menor = diff[N];
  assign cero  = (cnt_q == CNT_W'(1));
  assign div0  = (divisor == '0);

  always_comb begin
    a_d   = a_q;
    q_d   = q_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    dz_d  = dz_q;
    if (carga) begin
      a_d   = '0;
      q_d   = dividendo;
      m_d   = divisor;
      cnt_d = CNT_W'(N);
      dz_d  = div0;
    end else if (desplaza) begin
      {a_d, q_d} = {a_q[N-1:0], q_q, 1'b0};
    end else if (resta_ok) begin
      if (!menor) begin
        a_d    = diff;
        q_d[0] = 1'b1;
      end
      if (decrementa) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
      dz_q  <= dz_d;
    end
  end

  assign a  = a_q;
  assign q  = q_q;
  assign dz = dz_q;

endmodule

// File: rtl/divisor_rest.sv
// rtl/divisor_rest.sv - unsigned restoring divider: control FSM driving the cd_divisor datapath
module divisor_rest
  import divisor_rest_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] cociente,
  output logic [N-1:0] resto,
  output logic         fin,
  output logic         div_cero
);

  state_t       state_q, state_d;
  logic         carga, desplaza, resta_ok, decrementa;
  logic         cero, menor, div0, dz;
  logic [N:0]   a;
  logic [N-1:0] q;

  // A start seen mid-operation suppresses the datapath step so the abort is clean.
  assign carga      = (state_q == CARGA);
  assign desplaza   = (state_q == DESPLAZA) && !start;
  assign resta_ok   = (state_q == RESTA) && !start;
  assign decrementa = (state_q == RESTA) && !start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = start ? CARGA : IDLE;
      CARGA:    state_d = start ? CARGA : (div0 ? FIN : DESPLAZA);
      DESPLAZA: state_d = start ? CARGA : RESTA;
      RESTA:    state_d = start ? CARGA : (cero ? FIN : DESPLAZA);
      FIN:      state_d = start ? CARGA : FIN;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  cd_divisor #(.N(N)) u_cd (
    .clk        (clk),
    .reset_n    (reset_n),
    .carga      (carga),
    .desplaza   (desplaza),
    .resta_ok   (resta_ok),
    .decrementa (decrementa),
    .dividendo  (dividendo),
    .divisor    (divisor),
    .cero       (cero),
    .menor      (menor),
    .div0       (div0),
    .a          (a),
    .q          (q),
    .dz         (dz)
  );

  // On divide-by-zero Q still holds the captured dividend; present it as the remainder.
  assign cociente = dz ? '1 : q;
  assign resto    = dz ? q : a[N-1:0];
  assign fin      = (state_q == FIN);
  assign div_cero = dz;

endmodule
